// File: rtl/spi_rom_pkg.sv
// spi_rom_pkg: state encoding, TX word bit positions and length limits
// shared by spi_flash_reader and spi_rx_unpack.
package spi_rom_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR     = 3'd1;
    localparam logic [2:0] ST_OP      = 3'd2;
    localparam logic [2:0] ST_A2      = 3'd3;
    localparam logic [2:0] ST_A1      = 3'd4;
    localparam logic [2:0] ST_A0      = 3'd5;
    localparam logic [2:0] ST_DUMMY   = 3'd6;
    localparam logic [2:0] ST_WAIT_RX = 3'd7;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        HDR     = ST_HDR,
        OP      = ST_OP,
        A2      = ST_A2,
        A1      = ST_A1,
        A0      = ST_A0,
        DUMMY   = ST_DUMMY,
        WAIT_RX = ST_WAIT_RX
    } state_t;

    localparam int HDR_FLAG = 8;
    localparam int RD_WR    = 7;

    localparam logic [6:0] MAX_LEN   = 7'd123;
    localparam logic [6:0] CMD_BYTES = 7'd4;

    function automatic logic len_ok(input logic [6:0] len);
        return (len != 7'd0) && (len <= MAX_LEN);
    endfunction

endpackage

// File: rtl/spi_rx_unpack.sv
// spi_rx_unpack: pops the SPI RX FIFO one read at a time, counts returned
// bytes, drops the opcode/address echo and presents payload bytes.
// Ports: i_clk/i_rst clock and sync reset; i_clr clears on a new transaction;
// i_en enables reads while busy; i_total = payload + command bytes;
// i_rx_dout/i_rx_empty/o_rx_rd RX FIFO side; o_data_out/o_data_valid
// consumer side; o_byte marks a returned byte; o_last marks the final one.
module spi_rx_unpack
    import spi_rom_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [6:0] i_total,
    input  logic [7:0] i_rx_dout,
    input  logic       i_rx_empty,
    output logic       o_rx_rd,
    output logic [7:0] o_data_out,
    output logic       o_data_valid,
    output logic       o_byte,
    output logic       o_last
);

    logic       r_rd_q;
    logic [6:0] r_cnt;
    logic       w_rd;

    // r_rd_q doubles as "read outstanding": no back-to-back reads, and
    // r_cnt is exact whenever a new read is considered.
    assign w_rd = i_en && !i_rx_empty && !r_rd_q && (r_cnt < i_total);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_rd_q <= 1'b0;
            r_cnt  <= 7'd0;
        end else begin
            r_rd_q <= w_rd;
            if (r_rd_q) begin
                r_cnt <= r_cnt + 7'd1;
            end
        end
    end

    // Returned data is valid the cycle after the read strobe.
    assign o_byte       = r_rd_q && i_en;
    assign o_data_valid = o_byte && (r_cnt >= CMD_BYTES);
    assign o_data_out   = o_data_valid ? i_rx_dout : 8'h00;
    assign o_last       = o_byte && (r_cnt == i_total - 7'd1);
    assign o_rx_rd      = w_rd;

endmodule

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: frames a flash read (header, opcode, 24-bit address,
// dummy bytes) into the SPI TX FIFO and streams the payload from the RX FIFO.
// Ports: i_clk/i_rst; i_start/i_addr/i_len request; o_busy/o_done/o_err
// status; o_data_out/o_data_valid payload; o_tx_din/o_tx_wr/i_tx_full TX
// FIFO; i_rx_dout/o_rx_rd/i_rx_empty RX FIFO.
module spi_flash_reader
    import spi_rom_pkg::*;
#(
    parameter logic [7:0] READ_OP    = 8'h03,
    parameter logic [7:0] DUMMY_BYTE = 8'h00,
    parameter int         TIMEOUT    = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [23:0] i_addr,
    input  logic [6:0]  i_len,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [7:0]  o_data_out,
    output logic        o_data_valid,
    output logic [8:0]  o_tx_din,
    output logic        o_tx_wr,
    input  logic        i_tx_full,
    input  logic [7:0]  i_rx_dout,
    output logic        o_rx_rd,
    input  logic        i_rx_empty
);

    localparam logic [12:0] TO_LAST = 13'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_busy;
    logic        r_err;
    logic [23:0] r_addr;
    logic [6:0]  r_len;
    logic [6:0]  r_total;
    logic [6:0]  r_dcnt;
    logic [12:0] r_to;

    logic        w_accept;
    logic        w_push;
    logic        w_tx_wr;
    logic [8:0]  w_tx_din;
    logic        w_byte;
    logic        w_last;

    assign w_accept = (r_state == IDLE) && i_start && len_ok(i_len);

    always_comb begin
        w_tx_din = 9'h000;
        w_push   = 1'b1;
        case (r_state)
            HDR: begin
                w_tx_din[HDR_FLAG] = 1'b1;
                w_tx_din[RD_WR]    = 1'b0;
                w_tx_din[6:0]      = r_total;
            end
            OP:      w_tx_din = {1'b0, READ_OP};
            A2:      w_tx_din = {1'b0, r_addr[23:16]};
            A1:      w_tx_din = {1'b0, r_addr[15:8]};
            A0:      w_tx_din = {1'b0, r_addr[7:0]};
            DUMMY:   w_tx_din = {1'b0, DUMMY_BYTE};
            default: w_push   = 1'b0;
        endcase
    end

    assign w_tx_wr = w_push && !i_tx_full;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= 24'h0;
            r_len   <= 7'd0;
            r_total <= 7'd0;
            r_dcnt  <= 7'd0;
            r_to    <= 13'd0;
        end else begin
            r_err <= 1'b0;
            if (r_state == IDLE) begin
                if (i_start) begin
                    if (len_ok(i_len)) begin
                        r_addr  <= i_addr;
                        r_len   <= i_len;
                        r_total <= i_len + CMD_BYTES;
                        r_to    <= 13'd0;
                        r_busy  <= 1'b1;
                        r_state <= HDR;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
            end else if (w_last) begin
                // Completion takes priority over a coincident timeout.
                r_busy  <= 1'b0;
                r_state <= IDLE;
            end else if (!w_byte && (r_to == TO_LAST)) begin
                r_err   <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= IDLE;
            end else begin
                r_to <= w_byte ? 13'd0 : r_to + 13'd1;
                if (w_tx_wr) begin
                    case (r_state)
                        HDR: r_state <= OP;
                        OP:  r_state <= A2;
                        A2:  r_state <= A1;
                        A1:  r_state <= A0;
                        A0: begin
                            r_dcnt  <= r_len;
                            r_state <= DUMMY;
                        end
                        DUMMY: begin
                            r_dcnt <= r_dcnt - 7'd1;
                            if (r_dcnt == 7'd1) begin
                                r_state <= WAIT_RX;
                            end
                        end
                        default: r_state <= r_state;
                    endcase
                end
            end
        end
    end

    spi_rx_unpack u_rx (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clr        (w_accept),
        .i_en         (r_busy),
        .i_total      (r_total),
        .i_rx_dout    (i_rx_dout),
        .i_rx_empty   (i_rx_empty),
        .o_rx_rd      (o_rx_rd),
        .o_data_out   (o_data_out),
        .o_data_valid (o_data_valid),
        .o_byte       (w_byte),
        .o_last       (w_last)
    );

    assign o_busy   = r_busy;
    assign o_done   = w_last;
    assign o_err    = r_err;
    assign o_tx_din = w_tx_din;
    assign o_tx_wr  = w_tx_wr;

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: directed bench with a loopback SPI FIFO model.
// Short TIMEOUT keeps the stall case brief.
module tb_spi_flash_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] addr = 24'h0;
    logic [6:0]  len = 7'd0;
    logic        busy, done, err, data_valid, tx_wr, rx_rd;
    logic [7:0]  data_out;
    logic [8:0]  tx_din;
    logic        tx_full = 1'b0;
    logic [7:0]  rx_dout = 8'h00;
    logic        rx_empty = 1'b1;
    logic        loop_en = 1'b1;
    logic        rx_hold = 1'b0;

    logic [7:0]  miso [0:127];
    logic [7:0]  rxq [$];
    int          mi = 0;

    logic [8:0]  txlog [$];
    logic [7:0]  dlog [$];
    int n_done = 0, n_err = 0, n_busy = 0, n_txwr = 0, n_wr_full = 0;
    logic        done_dv = 1'b0;
    logic [7:0]  done_data = 8'h00;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_flash_reader #(.TIMEOUT(64)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_addr       (addr),
        .i_len        (len),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_data_out   (data_out),
        .o_data_valid (data_valid),
        .o_tx_din     (tx_din),
        .o_tx_wr      (tx_wr),
        .i_tx_full    (tx_full),
        .i_rx_dout    (rx_dout),
        .o_rx_rd      (rx_rd),
        .i_rx_empty   (rx_empty)
    );

    // SPI + FIFO model: each non-header TX word clocks one MISO byte back.
    always @(posedge clk) begin
        if (rst) begin
            rxq.delete();
            rx_dout <= 8'h00;
            mi = 0;
        end else begin
            if (start && !busy) begin
                rxq.delete();
                mi = 0;
            end
            if (tx_wr && !tx_din[8] && loop_en) begin
                rxq.push_back(miso[mi]);
                mi = mi + 1;
            end
            if (rx_rd && rxq.size() > 0) begin
                rx_dout <= rxq.pop_front();
            end
        end
        rx_empty <= rx_hold || (rxq.size() == 0);
    end

    always @(negedge clk) begin
        if (tx_wr) begin
            txlog.push_back(tx_din);
            n_txwr = n_txwr + 1;
            if (tx_full) n_wr_full = n_wr_full + 1;
        end
        if (data_valid) dlog.push_back(data_out);
        if (done) begin
            n_done = n_done + 1;
            done_dv = data_valid;
            done_data = data_out;
        end
        if (err) n_err = n_err + 1;
        if (busy) n_busy = n_busy + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] tx_exp(input logic [23:0] a,
                                          input logic [6:0] l, input int i);
        case (i)
            0:       return {2'b10, 7'(l + 7'd4)};
            1:       return 9'h003;
            2:       return {1'b0, a[23:16]};
            3:       return {1'b0, a[15:8]};
            4:       return {1'b0, a[7:0]};
            default: return 9'h000;
        endcase
    endfunction

    task automatic do_start(input logic [23:0] a, input logic [6:0] l);
        @(negedge clk);
        addr = a;
        len = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int max);
        int base;
        int c;
        base = n_done + n_err;
        c = 0;
        while (n_done + n_err == base && c < max) begin
            @(negedge clk);
            c++;
        end
        chk("wait_bound", 32'(c < max), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_tx(input int t0, input int n);
        int c;
        c = 0;
        while (txlog.size() - t0 < n && c < 400) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("tx_wait_bound", 32'(c < 400), 32'd1);
    endtask

    task automatic check_tx(input string nm, input int t0,
                            input logic [23:0] a, input logic [6:0] l);
        chk({nm, "_txn"}, 32'(txlog.size() - t0), 32'(l) + 32'd5);
        for (int i = 0; i < int'(l) + 5; i++) begin
            chk($sformatf("%s_tx%0d", nm, i), 32'(txlog[t0 + i]),
                32'(tx_exp(a, l, i)));
        end
    endtask

    task automatic check_data(input string nm, input int d0, input int n);
        chk({nm, "_nbeats"}, 32'(dlog.size() - d0), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_d%0d", nm, i), 32'(dlog[d0 + i]),
                32'(miso[4 + i]));
        end
    endtask

    logic [8:0] exp1 [0:7] = '{9'h107, 9'h003, 9'h001, 9'h023,
                               9'h045, 9'h000, 9'h000, 9'h000};
    logic [7:0] dexp1 [0:2] = '{8'h11, 8'h22, 8'h33};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, d0, e0, dn0, b0, w0;

        for (int i = 0; i < 128; i++) miso[i] = 8'(i + 8'h40);
        miso[0] = 8'hAA; miso[1] = 8'hBB; miso[2] = 8'hCC; miso[3] = 8'hDD;
        miso[4] = 8'h11; miso[5] = 8'h22; miso[6] = 8'h33;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 32'({busy, done, err, data_valid, tx_wr, rx_rd,
                               tx_din, data_out}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Normal read
        t0 = txlog.size(); d0 = dlog.size(); dn0 = n_done; e0 = n_err;
        do_start(24'h012345, 7'd3);
        wait_end(200);
        chk("t1_txn", 32'(txlog.size() - t0), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t1_tx%0d", i), 32'(txlog[t0 + i]), 32'(exp1[i]));
        chk("t1_nbeats", 32'(dlog.size() - d0), 32'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("t1_d%0d", i), 32'(dlog[d0 + i]), 32'(dexp1[i]));
        chk("t1_done", 32'(n_done - dn0), 32'd1);
        chk("t1_done_with_last", 32'({done_dv, done_data}), 32'h133);
        chk("t1_no_err", 32'(n_err - e0), 32'd0);
        chk("t1_busy_low", 32'(busy), 32'd0);

        // TX backpressure during A1
        t0 = txlog.size(); d0 = dlog.size(); dn0 = n_done;
        do_start(24'h012345, 7'd3);
        wait_tx(t0, 3);
        tx_full = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t2_stalled", 32'(txlog.size() - t0), 32'd3);
        tx_full = 1'b0;
        wait_end(200);
        chk("t2_txn", 32'(txlog.size() - t0), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t2_tx%0d", i), 32'(txlog[t0 + i]), 32'(exp1[i]));
        for (int i = 0; i < 3; i++)
            chk($sformatf("t2_d%0d", i), 32'(dlog[d0 + i]), 32'(dexp1[i]));
        chk("t2_done", 32'(n_done - dn0), 32'd1);
        chk("t2_no_wr_when_full", 32'(n_wr_full), 32'd0);

        // Illegal lengths
        e0 = n_err; b0 = n_busy; w0 = n_txwr;
        do_start(24'h000010, 7'd0);
        repeat (2) @(negedge clk);
        chk("t3_err_len0", 32'(n_err - e0), 32'd1);
        do_start(24'h000010, 7'd124);
        repeat (2) @(negedge clk);
        chk("t3_err_len124", 32'(n_err - e0), 32'd2);
        chk("t3_busy_never", 32'(n_busy - b0), 32'd0);
        chk("t3_no_txwr", 32'(n_txwr - w0), 32'd0);

        for (int i = 0; i < 128; i++) miso[i] = 8'(i + 8'h40);

        // Timeout: no RX data at all
        loop_en = 1'b0;
        e0 = n_err; dn0 = n_done; b0 = n_busy;
        do_start(24'h000100, 7'd5);
        wait_end(300);
        chk("t4_err", 32'(n_err - e0), 32'd1);
        chk("t4_no_done", 32'(n_done - dn0), 32'd0);
        chk("t4_busy_cycles", 32'(n_busy - b0), 32'd64);
        chk("t4_busy_low", 32'(busy), 32'd0);
        loop_en = 1'b1;

        // Reset during DUMMY
        t0 = txlog.size();
        do_start(24'h00ABCD, 7'd100);
        wait_tx(t0, 10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_outs_zero", 32'({busy, done, err, data_valid, tx_wr, rx_rd,
                                 tx_din, data_out}), 32'd0);
        w0 = n_txwr;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_quiet", 32'(n_txwr - w0), 32'd0);
        t0 = txlog.size(); d0 = dlog.size();
        do_start(24'h00BEEF, 7'd1);
        wait_end(200);
        check_tx("t5", t0, 24'h00BEEF, 7'd1);
        check_data("t5", d0, 1);

        // Start while busy is ignored
        t0 = txlog.size(); d0 = dlog.size(); dn0 = n_done;
        rx_hold = 1'b1;
        do_start(24'hABCDEF, 7'd2);
        wait_tx(t0, 7);
        do_start(24'h555555, 7'd9);
        rx_hold = 1'b0;
        wait_end(200);
        check_tx("t6", t0, 24'hABCDEF, 7'd2);
        check_data("t6", d0, 2);
        chk("t6_done", 32'(n_done - dn0), 32'd1);
        t0 = txlog.size(); d0 = dlog.size();
        do_start(24'h0000FE, 7'd1);
        wait_end(200);
        check_tx("t6n", t0, 24'h0000FE, 7'd1);
        check_data("t6n", d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- Command sequencer directly upstream and downstream of the SPI master in the SPI ROM path.
- On a start request it writes a framed read transaction into the SPI master's TX FIFO: a header word, opcode 0x03, a 24-bit address and dummy bytes.
- It drains the SPI master's RX FIFO, drops the 4 bytes captured during the opcode/address phase, and streams the payload bytes out to the consumer.
- Bytes are counted on both sides and a timeout is applied if the link stalls.

Parameters:
- READ_OP, 8'h03, flash read opcode sent after the header.
- DUMMY_BYTE, 8'h00, MOSI value pushed for each payload byte.
- TIMEOUT, 4096, clk cycles allowed between RX bytes before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- addr  in  24  flash byte address; latched on accepted start
- len  in  7  payload byte count; legal range 1..123
- busy  out  1  high from accepted start until done/err
- done  out  1  one-cycle pulse after the last payload byte is output
- err  out  1  one-cycle pulse on illegal len or timeout
- data_out  out  8  payload byte
- data_valid  out  1  one-cycle qualifier for data_out
- tx_din  out  9  word to SPI TX FIFO; bit8=1 marks a header, bits[7:0]=data byte otherwise
- tx_wr  out  1  TX FIFO write strobe
- tx_full  in  1  TX FIFO full
- rx_dout  in  8  RX FIFO read data, valid the cycle after rx_rd
- rx_rd  out  1  RX FIFO read strobe
- rx_empty  in  1  RX FIFO empty

Behaviour:
- Reset:
  - busy, done, err, data_valid, tx_wr and rx_rd are 0.
  - tx_din and data_out are 0.
  - FSM is in IDLE and all counters are 0.
  - A reset mid-transaction aborts immediately. No further FIFO writes or reads occur. FIFO contents are not this block's concern.
- Start acceptance:
  - start in IDLE with len in 1..123 latches addr and len, sets busy on the next cycle, and moves to HDR.
  - If len is 0 or greater than 123, err pulses on the next cycle and the FSM stays in IDLE.
  - start while busy is ignored.
- TX FSM:
  - States: IDLE, HDR, OP, A2, A1, A0, DUMMY, WAIT_RX.
  - A state pushes its word by asserting tx_wr for one cycle with tx_din valid in that same cycle, and only when tx_full=0. While tx_full=1 the state holds with tx_wr=0.
  - HDR pushes {1'b1, 1'b0 (rd_wr=0, capture MISO), total[6:0]}, where total = len+4.
  - OP pushes {0, READ_OP}.
  - A2, A1, A0 push addr[23:16], addr[15:8] and addr[7:0] respectively.
  - DUMMY pushes {0, DUMMY_BYTE} len times using a 7-bit down-counter, then moves to WAIT_RX.
  - Minimum HDR-to-WAIT_RX time is 5+len cycles when the FIFO is never full.
- RX side (independent of the TX FSM while busy):
  - Assert rx_rd when rx_empty=0, with at most one read outstanding, i.e. no rx_rd in a cycle where the previous cycle had rx_rd.
  - Each returned byte increments the 7-bit rx_cnt.
  - Bytes with index 0..3 are discarded.
  - Bytes with index 4..len+3 drive data_out with data_valid=1 one cycle after the rx_rd cycle.
  - When rx_cnt reaches len+4, done pulses in the same cycle as the final data_valid. busy drops on the next cycle and the FSM returns to IDLE.
  - A read arriving during the TX phase is normal and handled concurrently.
- Timeout:
  - A 13-bit counter clears on every returned RX byte and on start acceptance, and increments while busy.
  - Reaching TIMEOUT pulses err, clears busy, returns to IDLE and drops any pending TX pushes.
  - done is not asserted on timeout.
- Simultaneous events: if the final byte and the timeout coincide, done wins and err stays low.
- Width rules: total = len+4 is computed in 7 bits. The legal len range guarantees no overflow.

Decomposition:
- Shared package spi_rom_pkg holds:
  - the state encoding localparams;
  - HDR_FLAG bit index 8 and RD_WR bit index 7;
  - MAX_LEN = 123;
  - CMD_BYTES = 4.
- Natural sub-module spi_rx_unpack: RX pop control, rx_cnt, discard of the first CMD_BYTES bytes, and data_valid generation. The top level keeps the TX FSM and the timeout.

Test Plan:
- Normal read: start with addr=0x012345, len=3, tx_full=0, and a bench FIFO model that loops back a fixed MISO sequence. TX words must be 0x107, 0x003, 0x001, 0x023, 0x045, 0x000, 0x000, 0x000. RX returns AA BB CC DD 11 22 33, so data_out must be 11, 22, 33. done must coincide with the 33 beat.
- TX backpressure: hold tx_full=1 for 10 cycles during A1. The stream must stall with no duplicated or dropped word, and the final TX sequence must be identical to the first test.
- Illegal len: len=0, then len=124. err must pulse once each, busy stays 0, and no tx_wr occurs.
- Timeout: TIMEOUT=64, RX never returns data. err must pulse 64 cycles after the last RX activity, busy drops, and done stays 0.
- Reset mid-operation: assert rst during DUMMY with len=100. All outputs must be 0 the next cycle. A new start with len=1 must then complete with exactly 6 TX words.
- Start while busy: pulse start during WAIT_RX. It must be ignored; the latched addr and len are unchanged, as checked on the TX words of the next accepted transaction.
